// File: rtl/mips_intc_pkg.sv
// rtl/mips_intc_pkg.sv - shared types, register map and helpers for the vectored interrupt controller
package mips_intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } intc_state_t;

    localparam logic [1:0] ADDR_IE   = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    localparam int STAT_GIE_BIT   = 0;
    localparam int STAT_EXL_BIT   = 1;
    localparam int STAT_STATE_LSB = 2;
    localparam int STAT_ID_LSB    = 4;
    localparam int STAT_DEPTH_LSB = 8;

    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [3:0]  id);
        return base + stride * {28'd0, id};
    endfunction

endpackage

// File: rtl/intc_sync.sv
// rtl/intc_sync.sv - two-flop synchroniser with rising-edge detect for one interrupt line
module intc_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_q;

    // Two flops resolve metastability; a third holds the previous synced value for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta   <= d;
            sync   <= meta;
            sync_q <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~sync_q;

endmodule

// File: rtl/mips_intc.sv
// rtl/mips_intc.sv - vectored interrupt controller top; optional nesting via MIPS_INTC_NEST_EN
module mips_intc
    import mips_intc_pkg::*;
#(
    parameter int          N_IRQ      = 6,
    parameter logic [31:0] VEC_BASE   = 32'h200,
    parameter logic [31:0] VEC_STRIDE = 32'h20,
    parameter int          NEST_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wd,
    output logic [31:0]      cfg_rd,
    input  logic             ack,
    input  logic             eret,
    output logic             iv,
    output logic [31:0]      vector,
    output logic             exl,
    output logic [3:0]       cur_id
);

    logic [N_IRQ-1:0] lvl;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] ie;
    logic [N_IRQ-1:0] edge_mode;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] pend_nxt;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] cand;
    logic             cand_any;
    logic [3:0]       cand_id;
    logic             gie;
    logic             req;
    logic [3:0]       req_id;
    logic [3:0]       depth;
    logic [3:0]       stack_top;
    logic             stack_nz;
    logic [31:0]      status;
    intc_state_t      state;

    logic unused_wd;
    assign unused_wd = ^cfg_wd[31:N_IRQ];

    genvar g;
    generate
        for (g = 0; g < N_IRQ; g++) begin : g_sync
            intc_sync u_sync (
                .clk   (clk),
                .rst   (rst),
                .d     (irq_in[g]),
                .level (lvl[g]),
                .rise  (rise[g])
            );
        end
    endgenerate

    assign cand     = pend & ie;
    assign cand_any = |cand;

    // Lowest enabled pending index wins
    always_comb begin
        cand_id = 4'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) cand_id = 4'(i);
        end
    end

`ifdef MIPS_INTC_NEST_EN
    localparam logic [3:0] NEST_MAX = 4'(NEST_DEPTH);

    logic [NEST_DEPTH*4-1:0] stack;
    logic                    nest_ok;
    logic                    do_push;
    logic                    do_pop;

    assign nest_ok  = exl && (cand_id < cur_id) && (depth < NEST_MAX);
    assign req      = gie && cand_any && (!exl || nest_ok);
    assign stack_nz = (depth != 4'd0);
    assign do_push  = (state == ST_REQ) && ack && exl;
    assign do_pop   = (state == ST_SVC) && eret && stack_nz;

    // Saved-id stack entry at the current top of stack
    always_comb begin
        stack_top = 4'd0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (depth == 4'(i + 1)) stack_top = stack[i*4 +: 4];
        end
    end

    // Push the interrupted id on a nested take, pop it on ERET
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stack <= '0;
            depth <= 4'd0;
        end else if (do_push) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (depth == 4'(i)) stack[i*4 +: 4] <= cur_id;
            end
            depth <= depth + 4'd1;
        end else if (do_pop) begin
            depth <= depth - 4'd1;
        end
    end
`else
    assign req       = gie && !exl && cand_any;
    assign depth     = 4'd0;
    assign stack_top = 4'd0;
    assign stack_nz  = 1'b0;
`endif

    // Bits to clear this cycle: W1C write plus the channel being taken; a fresh edge overrides both
    always_comb begin
        clr = '0;
        if (cfg_we && cfg_addr == ADDR_PEND) clr = cfg_wd[N_IRQ-1:0];
        if (state == ST_REQ && ack) begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (req_id == 4'(i)) clr[i] = 1'b1;
            end
        end
        pend_nxt = (edge_mode & ((pend & ~clr) | rise)) | (~edge_mode & lvl);
    end

    // Config registers, pending latch and the request/service FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie        <= '0;
            edge_mode <= '0;
            pend      <= '0;
            gie       <= 1'b0;
            state     <= ST_IDLE;
            iv        <= 1'b0;
            exl       <= 1'b0;
            cur_id    <= 4'd0;
            req_id    <= 4'd0;
            vector    <= VEC_BASE;
        end else begin
            pend <= pend_nxt;
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_IE:   ie        <= cfg_wd[N_IRQ-1:0];
                    ADDR_EDGE: edge_mode <= cfg_wd[N_IRQ-1:0];
                    ADDR_STAT: gie       <= cfg_wd[STAT_GIE_BIT];
                    default:   ;
                endcase
            end
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state  <= ST_REQ;
                        iv     <= 1'b1;
                        req_id <= cand_id;
                        vector <= vec_addr(VEC_BASE, VEC_STRIDE, cand_id);
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        cur_id <= req_id;
                        exl    <= 1'b1;
                        iv     <= 1'b0;
                        state  <= ST_SVC;
                    end else if (!req) begin
                        iv    <= 1'b0;
                        state <= exl ? ST_SVC : ST_IDLE;
                    end else begin
                        req_id <= cand_id;
                        vector <= vec_addr(VEC_BASE, VEC_STRIDE, cand_id);
                    end
                end
                ST_SVC: begin
                    if (eret) begin
                        if (stack_nz) begin
                            cur_id <= stack_top;
                        end else begin
                            exl   <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else if (req) begin
                        state  <= ST_REQ;
                        iv     <= 1'b1;
                        req_id <= cand_id;
                        vector <= vec_addr(VEC_BASE, VEC_STRIDE, cand_id);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // STATUS word assembly
    always_comb begin
        status                          = '0;
        status[STAT_GIE_BIT]            = gie;
        status[STAT_EXL_BIT]            = exl;
        status[STAT_STATE_LSB +: 2]     = state;
        status[STAT_ID_LSB +: 4]        = cur_id;
        status[STAT_DEPTH_LSB +: 4]     = depth;
    end

    // Combinational register read
    always_comb begin
        case (cfg_addr)
            ADDR_IE:   cfg_rd = {{(32-N_IRQ){1'b0}}, ie};
            ADDR_EDGE: cfg_rd = {{(32-N_IRQ){1'b0}}, edge_mode};
            ADDR_PEND: cfg_rd = {{(32-N_IRQ){1'b0}}, pend};
            default:   cfg_rd = status;
        endcase
    end

endmodule

// File: tb/tb_mips_intc.sv
// tb/tb_mips_intc.sv - randomized self-checking bench for mips_intc against a behavioural model
module tb_mips_intc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  irq_in = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wd = '0;
    logic        ack = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] cfg_rd;
    logic        iv;
    logic [31:0] vector;
    logic        exl;
    logic [3:0]  cur_id;

    mips_intc dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wd   (cfg_wd),
        .cfg_rd   (cfg_rd),
        .ack      (ack),
        .eret     (eret),
        .iv       (iv),
        .vector   (vector),
        .exl      (exl),
        .cur_id   (cur_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 requesting, 2 in service
    int          m_phase;
    logic        m_iv, m_exl, m_gie;
    logic [3:0]  m_cur, m_id;
    logic [31:0] m_vec;
    logic [5:0]  m_pend, m_ie, m_edge;
    logic [5:0]  h1, h2, h3;   // raw samples from 1, 2 and 3 edges ago

    function automatic int m_cand();
        for (int i = 0; i < 6; i++) if (m_pend[i] && m_ie[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0: return {26'd0, m_ie};
            2'd1: return {26'd0, m_edge};
            2'd2: return {26'd0, m_pend};
            default: return 32'(m_cur) * 16 + 32'(m_phase) * 4 + 32'(m_exl) * 2 + 32'(m_gie);
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_iv = 0; m_exl = 0; m_gie = 0; m_cur = 0; m_id = 0;
        m_vec = 32'h200; m_pend = 0; m_ie = 0; m_edge = 0; h1 = 0; h2 = 0; h3 = 0;
    endtask

    task automatic model_step();
        logic [5:0] lvl, rise, clr;
        int c;
        logic rq;
        if (!rst) begin
            model_reset();
            return;
        end
        lvl  = h2;
        rise = h2 & ~h3;
        clr  = 0;
        c    = m_cand();
        rq   = m_gie && !m_exl && (c >= 0);
        case (m_phase)
            0: if (rq) begin
                m_phase = 1; m_iv = 1; m_id = 4'(c); m_vec = 32'h200 + 32'(32'h20 * c);
            end
            1: if (ack) begin
                m_cur = m_id; m_exl = 1; clr[m_id] = 1'b1; m_iv = 0; m_phase = 2;
            end else if (!rq) begin
                m_iv = 0; m_phase = 0;
            end else begin
                m_id = 4'(c); m_vec = 32'h200 + 32'(32'h20 * c);
            end
            default: if (eret) begin
                m_exl = 0; m_phase = 0;
            end
        endcase
        if (cfg_we && cfg_addr == 2'd2) clr = clr | cfg_wd[5:0];
        for (int i = 0; i < 6; i++)
            m_pend[i] = m_edge[i] ? ((m_pend[i] & ~clr[i]) | rise[i]) : lvl[i];
        if (cfg_we) begin
            case (cfg_addr)
                2'd0: m_ie = cfg_wd[5:0];
                2'd1: m_edge = cfg_wd[5:0];
                2'd3: m_gie = cfg_wd[0];
                default: ;
            endcase
        end
        h3 = h2; h2 = h1; h1 = irq_in;
    endtask

    // Compare process: every cycle out of reset, DUT outputs against the model
    always @(posedge clk) begin
        #1;
        if (rst) begin
            check("iv", 32'(iv), 32'(m_iv));
            check("exl", 32'(exl), 32'(m_exl));
            check("cur_id", 32'(cur_id), 32'(m_cur));
            if (m_iv) check("vector", vector, m_vec);
            check("cfg_rd", cfg_rd, m_read(cfg_addr));
        end
    end

    logic [5:0] cur_irq = '0;
    logic [1:0] rd_addr = '0;

    task automatic cyc(input logic [5:0] irq, input logic a, input logic e,
                       input logic we, input logic [1:0] addr, input logic [31:0] wd);
        @(negedge clk);
        irq_in = irq; ack = a; eret = e; cfg_we = we; cfg_addr = addr; cfg_wd = wd;
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) cyc(cur_irq, 1'b0, 1'b0, 1'b0, rd_addr, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(cur_irq, 1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic wait_iv(input int maxc, output int n);
        n = -1;
        for (int k = 1; k <= maxc; k++) begin
            step(1);
            if (iv) begin
                n = k;
                break;
            end
        end
    endtask

    int n;

    initial begin
        model_reset();
        // T1 reset
        rst = 0; cur_irq = 6'h3F;
        step(3);
        check("t1_iv", 32'(iv), 32'd0);
        check("t1_exl", 32'(exl), 32'd0);
        check("t1_vector", vector, 32'h200);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            check("t1_cfg_rd", cfg_rd, 32'd0);
        end
        cur_irq = 0;
        step(1);
        rst = 1;

        // T2 single edge
        wr(2'd0, 32'h04); wr(2'd1, 32'h04); wr(2'd3, 32'h1);
        cyc(6'h04, 0, 0, 0, 2'd0, 0);
        wait_iv(6, n);
        check("t2_latency", 32'((n >= 3) && (n <= 4)), 32'd1);
        check("t2_vector", vector, 32'h240);
        cyc(cur_irq, 1, 0, 0, 2'd2, 0);
        check("t2_ack_exl", 32'(exl), 32'd1);
        check("t2_ack_iv", 32'(iv), 32'd0);
        check("t2_ack_pend", cfg_rd, 32'd0);
        cyc(cur_irq, 0, 1, 0, 2'd2, 0);
        check("t2_eret_exl", 32'(exl), 32'd0);

        // T3 priority, level mode
        wr(2'd1, 32'h0); wr(2'd0, 32'h3F);
        cur_irq = 6'h22;
        wait_iv(8, n);
        check("t3_vec_ch1", vector, 32'h220);
        cyc(cur_irq, 1, 0, 0, 2'd3, 0);
        cur_irq = 6'h20;
        step(4);
        cyc(cur_irq, 0, 1, 0, 2'd3, 0);
        wait_iv(4, n);
        check("t3_vec_ch5", vector, 32'h2A0);
        cur_irq = 0;
        step(6);
        check("t3_iv_drop", 32'(iv), 32'd0);

        // T4 mask and W1C
        wr(2'd0, 32'h0); wr(2'd1, 32'h08);
        cyc(6'h08, 0, 0, 0, 2'd0, 0);
        step(5);
        check("t4_masked_iv", 32'(iv), 32'd0);
        rd_addr = 2'd2;
        step(1);
        check("t4_pend", cfg_rd, 32'h08);
        wr(2'd2, 32'h08);
        check("t4_w1c", cfg_rd, 32'd0);
        wr(2'd0, 32'h08);
        step(5);
        check("t4_no_iv", 32'(iv), 32'd0);

        // T5 collisions
        wr(2'd0, 32'h04); wr(2'd1, 32'h04);
        cyc(6'h04, 0, 0, 0, 2'd2, 0);
        wait_iv(6, n);
        check("t5_iv", 32'(n > 0), 32'd1);
        cyc(6'h04, 0, 0, 0, 2'd2, 0);
        cyc(6'h00, 0, 0, 0, 2'd2, 0);
        cyc(6'h00, 1, 0, 0, 2'd2, 0);
        check("t5_pend_kept", cfg_rd, 32'h04);
        check("t5_exl", 32'(exl), 32'd1);
        cyc(6'h00, 0, 1, 0, 2'd2, 0);
        wait_iv(3, n);
        check("t5_reraise", 32'(n > 0), 32'd1);
        cyc(6'h00, 1, 0, 0, 2'd2, 0);
        cyc(6'h00, 0, 1, 0, 2'd2, 0);
        rd_addr = 2'd3;
        step(2);
        cyc(6'h00, 0, 1, 0, 2'd3, 0);
        check("t5_eret_idle", cfg_rd, 32'h21);
        check("t5_eret_iv", 32'(iv), 32'd0);

        // T6 no nesting: ch0 waits for eret
        wr(2'd0, 32'h11); wr(2'd1, 32'h11);
        cyc(6'h10, 0, 0, 0, 2'd3, 0);
        wait_iv(6, n);
        check("t6_vec_ch4", vector, 32'h280);
        cyc(6'h00, 1, 0, 0, 2'd3, 0);
        cyc(6'h01, 0, 0, 0, 2'd3, 0);
        step(6);
        check("t6_blocked", 32'(iv), 32'd0);
        cyc(6'h00, 0, 1, 0, 2'd3, 0);
        wait_iv(3, n);
        check("t6_vec_ch0", vector, 32'h200);

        // Asynchronous reset mid-request
        #1;
        rst = 0;
        #1;
        check("rst_async_iv", 32'(iv), 32'd0);
        check("rst_async_exl", 32'(exl), 32'd0);
        check("rst_async_vec", vector, 32'h200);
        step(2);
        rst = 1;

        // Randomized phase
        wr(2'd3, 32'h1);
        for (int k = 0; k < 3000; k++) begin
            logic [5:0]  flip;
            logic [31:0] wd;
            logic [1:0]  ad;
            logic        we;
            for (int b = 0; b < 6; b++) flip[b] = ($urandom % 8 == 0);
            cur_irq = cur_irq ^ flip;
            we = ($urandom % 10 == 0);
            ad = 2'($urandom % 4);
            wd = $urandom;
            if (ad == 2'd3) wd[0] = ($urandom % 6 != 0);
            cyc(cur_irq, ($urandom % 3 == 0), ($urandom % 4 == 0), we, ad, wd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
